// File: rtl/game_round_sequencer_pkg.sv
// game_round_sequencer_pkg: state encoding and default match configuration shared by the sequencer files.
package game_round_sequencer_pkg;
  localparam logic [1:0] GAME_ROUND_IDLE  = 2'd0;
  localparam logic [1:0] GAME_ROUND_PLAY  = 2'd1;
  localparam logic [1:0] GAME_ROUND_TALLY = 2'd2;
  localparam logic [1:0] GAME_ROUND_OVER  = 2'd3;
  localparam int ROUNDS_PER_MATCH_D = 8;
  localparam int W_SCORE_D          = 4;
  localparam int W_SPEED_D          = 3;
  localparam int SPEED_MIN_D        = 1;
  localparam int SPEED_MAX_D        = 6;
  localparam int LIVES_D            = 3;
endpackage

// File: rtl/game_round_sequencer_if.sv
// game_round_sequencer_if: player/round-master inputs and display/datapath outputs of the match sequencer.
// Carries lives_left only when GAME_ROUND_SEQUENCER_LIVES_EN is defined.
interface game_round_sequencer_if #(
  parameter int W_SCORE = 4,
  parameter int W_SPEED = 3
);
  logic               key;
  logic               round_done;
  logic               round_won;
  logic               round_enable;
  logic [W_SPEED-1:0] target_speed;
  logic [W_SCORE-1:0] score;
  logic [3:0]         round_count;
  logic               match_over;
  logic               match_won;
`ifdef GAME_ROUND_SEQUENCER_LIVES_EN
  logic [1:0]         lives_left;
  modport master (output key, round_done, round_won,
                  input  round_enable, target_speed, score, round_count, match_over, match_won, lives_left);
  modport slave  (input  key, round_done, round_won,
                  output round_enable, target_speed, score, round_count, match_over, match_won, lives_left);
`else
  modport master (output key, round_done, round_won,
                  input  round_enable, target_speed, score, round_count, match_over, match_won);
  modport slave  (input  key, round_done, round_won,
                  output round_enable, target_speed, score, round_count, match_over, match_won);
`endif
endinterface

// File: rtl/game_key_edge.sv
// game_key_edge: registered rising-edge detector for an already-synchronised key level.
module game_key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic key_rise
);
  logic key_prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) key_prev <= 1'b0;
    else key_prev <= key;
  assign key_rise = key & ~key_prev;
endmodule

// File: rtl/game_round_sequencer.sv
// game_round_sequencer: match-level FSM that counts rounds, keeps score and adapts target speed.
// Optional GAME_ROUND_SEQUENCER_LIVES_EN adds a lives counter that can end the match early.
module game_round_sequencer
  import game_round_sequencer_pkg::*;
#(
  parameter int ROUNDS_PER_MATCH = ROUNDS_PER_MATCH_D,
  parameter int W_SCORE          = W_SCORE_D,
  parameter int W_SPEED          = W_SPEED_D,
  parameter int SPEED_MIN        = SPEED_MIN_D,
`ifdef GAME_ROUND_SEQUENCER_LIVES_EN
  parameter int LIVES            = LIVES_D,
`endif
  parameter int SPEED_MAX        = SPEED_MAX_D
) (
  input logic clk,
  input logic reset,
  game_round_sequencer_if.slave bus
);
  localparam logic [W_SPEED-1:0] S_MIN = W_SPEED'(SPEED_MIN);
  localparam logic [W_SPEED-1:0] S_MAX = W_SPEED'(SPEED_MAX);
  localparam logic [3:0] R_LAST = 4'(ROUNDS_PER_MATCH);
  localparam int WC = W_SCORE + 1;
  logic [1:0] state;
  logic key_rise, won_q, en, over, mwon, ended, win_n;
  logic [W_SPEED-1:0] speed, speed_n;
  logic [W_SCORE-1:0] score, score_n;
  logic [3:0] count, count_n;
`ifdef GAME_ROUND_SEQUENCER_LIVES_EN
  logic [1:0] lives, lives_n;
  assign bus.lives_left = lives;
`endif

  game_key_edge u_key_edge (.clk(clk), .reset(reset), .key(bus.key), .key_rise(key_rise));

  // Results of the round being tallied; only committed in TALLY.
  always_comb begin
    count_n = count + 4'd1;
    score_n = (won_q && !(&score)) ? score + 1'b1 : score;
    speed_n = won_q ? (speed < S_MAX ? speed + 1'b1 : speed) : (speed > S_MIN ? speed - 1'b1 : speed);
    win_n = {score_n, 1'b0} > WC'(count_n);
`ifdef GAME_ROUND_SEQUENCER_LIVES_EN
    lives_n = won_q ? lives : lives - 2'd1;
    ended = count_n == R_LAST || lives_n == 2'd0;
    win_n = win_n && lives_n != 2'd0;
`else
    ended = count_n == R_LAST;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= GAME_ROUND_IDLE;
      en    <= 1'b0;
      speed <= S_MIN;
      score <= '0;
      count <= '0;
      over  <= 1'b0;
      mwon  <= 1'b0;
      won_q <= 1'b0;
`ifdef GAME_ROUND_SEQUENCER_LIVES_EN
      lives <= 2'(LIVES);
`endif
    end else begin
      case (state)
        GAME_ROUND_IDLE:
          if (key_rise) begin
            state <= GAME_ROUND_PLAY;
            en    <= 1'b1;
            speed <= S_MIN;
            score <= '0;
            count <= '0;
`ifdef GAME_ROUND_SEQUENCER_LIVES_EN
            lives <= 2'(LIVES);
`endif
          end
        GAME_ROUND_PLAY:
          if (bus.round_done) begin
            state <= GAME_ROUND_TALLY;
            en    <= 1'b0;
            won_q <= bus.round_won;
          end
        GAME_ROUND_TALLY: begin
          count <= count_n;
          score <= score_n;
          speed <= speed_n;
`ifdef GAME_ROUND_SEQUENCER_LIVES_EN
          lives <= lives_n;
`endif
          state <= ended ? GAME_ROUND_OVER : GAME_ROUND_PLAY;
          en    <= !ended;
          over  <= ended;
          if (ended) mwon <= win_n;
        end
        GAME_ROUND_OVER:
          if (key_rise) begin
            state <= GAME_ROUND_IDLE;
            over  <= 1'b0;
          end
        default: state <= GAME_ROUND_IDLE;
      endcase
    end
  end

  assign bus.round_enable = en;
  assign bus.target_speed = speed;
  assign bus.score        = score;
  assign bus.round_count  = count;
  assign bus.match_over   = over;
  assign bus.match_won    = mwon;
endmodule

// File: tb/tb_game_round_sequencer.sv
// tb_game_round_sequencer: directed match scenarios plus random stimulus against a behavioural match model.
module tb_game_round_sequencer;
  localparam int RPM = 8, SMIN = 1, SMAX = 6, LIV = 3, SCORE_MAX = 15;
`ifdef GAME_ROUND_SEQUENCER_LIVES_EN
  localparam bit LIVES_ON = 1'b1;
`else
  localparam bit LIVES_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  game_round_sequencer_if #(.W_SCORE(4), .W_SPEED(3)) bus ();
  game_round_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  int m_en, m_speed, m_score, m_rounds, m_over, m_won, m_pend, m_lives;
  bit m_prev, m_rise;

  // Match model: a pending round result is applied one cycle after round_done.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en = 0; m_speed = SMIN; m_score = 0; m_rounds = 0; m_over = 0; m_won = 0;
      m_pend = -1; m_prev = 0; m_lives = LIV;
    end else begin
      m_rise = bus.key && !m_prev;
      m_prev = bus.key;
      if (m_pend >= 0) begin
        m_rounds++;
        if (m_pend == 1) begin
          m_score = (m_score < SCORE_MAX) ? m_score + 1 : m_score;
          m_speed = (m_speed < SMAX) ? m_speed + 1 : SMAX;
        end else begin
          m_speed = (m_speed > SMIN) ? m_speed - 1 : SMIN;
          m_lives--;
        end
        if (m_rounds == RPM || (LIVES_ON && m_lives == 0)) begin
          m_over = 1;
          m_en = 0;
          m_won = (LIVES_ON && m_lives == 0) ? 0 : int'(m_score * 2 > m_rounds);
        end else m_en = 1;
        m_pend = -1;
      end else if (m_en != 0) begin
        if (bus.round_done) begin m_pend = int'(bus.round_won); m_en = 0; end
      end else if (m_over != 0) begin
        if (m_rise) m_over = 0;
      end else if (m_rise) begin
        m_en = 1; m_speed = SMIN; m_score = 0; m_rounds = 0; m_lives = LIV;
      end
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("round_enable", int'(bus.round_enable), m_en);
    chk("target_speed", int'(bus.target_speed), m_speed);
    chk("score", int'(bus.score), m_score);
    chk("round_count", int'(bus.round_count), m_rounds);
    chk("match_over", int'(bus.match_over), m_over);
    if (m_over != 0) chk("match_won", int'(bus.match_won), m_won);
`ifdef GAME_ROUND_SEQUENCER_LIVES_EN
    chk("lives_left", int'(bus.lives_left), m_lives);
`endif
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press();
    bus.key = 1'b1; tick();
    bus.key = 1'b0; tick();
  endtask

  task automatic play_round(input bit w, input bit k = 1'b0);
    int n = 0;
    while (!bus.round_enable && n < 20) begin tick(); n++; end
    chk("round_start", int'(bus.round_enable), 1);
    bus.round_done = 1'b1; bus.round_won = w;
    if (k) bus.key = 1'b1;
    tick();
    bus.round_done = 1'b0; bus.round_won = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key = 1'b0; bus.round_done = 1'b0; bus.round_won = 1'b0;
    repeat (3) tick();
    chk("lit_reset_en", int'(bus.round_enable), 0);
    chk("lit_reset_speed", int'(bus.target_speed), 1);
    chk("lit_reset_over", int'(bus.match_over), 0);
    reset = 1'b0;
    tick();
    bus.key = 1'b1; tick();
    chk("lit_start_en", int'(bus.round_enable), 1);
    chk("lit_start_speed", int'(bus.target_speed), 1);
    chk("lit_start_count", int'(bus.round_count), 0);
    bus.key = 1'b0; tick();
    repeat (3) play_round(1'b1);
    chk("lit_3win_score", int'(bus.score), 3);
    chk("lit_3win_speed", int'(bus.target_speed), 4);
    chk("lit_3win_count", int'(bus.round_count), 3);
    repeat (4) play_round(1'b1);
    chk("lit_7win_speed", int'(bus.target_speed), 6);
    play_round(1'b0);
    chk("lit_m1_over", int'(bus.match_over), 1);
    chk("lit_m1_won", int'(bus.match_won), 1);
    chk("lit_m1_score", int'(bus.score), 7);
    chk("lit_m1_speed", int'(bus.target_speed), 5);
    chk("lit_m1_count", int'(bus.round_count), 8);
    repeat (3) begin bus.round_done = 1'b1; bus.round_won = 1'b1; tick(); bus.round_done = 1'b0; tick(); end
    chk("lit_over_hold_count", int'(bus.round_count), 8);
    press();
    chk("lit_idle_over", int'(bus.match_over), 0);
    repeat (2) begin bus.round_done = 1'b1; tick(); bus.round_done = 1'b0; tick(); end
    press();
    play_round(1'b0);
    chk("lit_loss_min_speed", int'(bus.target_speed), 1);
    play_round(1'b1); play_round(1'b1); play_round(1'b0);
    play_round(1'b1); play_round(1'b1); play_round(1'b1);
    play_round(1'b1, 1'b1);
    chk("lit_m2_over", int'(bus.match_over), 1);
    chk("lit_m2_score", int'(bus.score), 6);
    chk("lit_m2_speed", int'(bus.target_speed), 6);
    repeat (4) tick();
    chk("lit_key_held_over", int'(bus.match_over), 1);
    bus.key = 1'b0; tick();
    chk("lit_key_release_over", int'(bus.match_over), 1);
    press();
    chk("lit_m2_idle", int'(bus.match_over), 0);
    press();
    play_round(1'b1); play_round(1'b1);
    bus.round_done = 1'b1; bus.round_won = 1'b1; tick();
    bus.round_done = 1'b0; bus.round_won = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("lit_tally_reset_en", int'(bus.round_enable), 0);
    chk("lit_tally_reset_score", int'(bus.score), 0);
    chk("lit_tally_reset_count", int'(bus.round_count), 0);
    chk("lit_tally_reset_speed", int'(bus.target_speed), 1);
    tick(); reset = 1'b0; tick();
`ifdef GAME_ROUND_SEQUENCER_LIVES_EN
    press();
    repeat (3) play_round(1'b0);
    chk("lit_lives_zero", int'(bus.lives_left), 0);
    chk("lit_lives_over", int'(bus.match_over), 1);
    chk("lit_lives_won", int'(bus.match_won), 0);
    chk("lit_lives_count", int'(bus.round_count), 3);
    press();
`endif
    for (int i = 0; i < 600; i++) begin
      tick();
      #1;
      if ($urandom_range(0, 3) == 0) bus.key = ~bus.key;
      bus.round_done = ($urandom_range(0, 2) == 0);
      bus.round_won = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 149) == 0);
    end
    tick();
    reset = 1'b0; bus.round_done = 1'b0; bus.key = 1'b0;
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
